btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/btn_conditioner.sv | 104 ++++++++++
 tb/tb_btn_conditioner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the push-button conditioner and the PicoBlaze ports around it.
// Holds the board-clock debounce default, the port map and the pad idle level.
package btn_conditioner_pkg;

    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned DEBOUNCE_1MS = CLK_HZ / 1000;

    localparam logic [7:0] PORT_CLR   = 8'h00;
    localparam logic [7:0] PORT_LEVEL = 8'h01;
    localparam logic [7:0] PORT_FLAG  = 8'h02;
    localparam logic [7:0] PORT_CNT   = 8'h03;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

    function automatic logic isPortWrite(input logic strobe,
                                         input logic [7:0] portId,
                                         input logic [7:0] id);
        return strobe && (portId == id);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad input.
// Both flops reset to RESET_VAL so the output never shows a false edge after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions one active-low button pin: synchronise, debounce, and report press/release
// pulses plus a sticky flag and wrapping press counter that the CPU clears by port write.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = DEBOUNCE_1MS,
    parameter int unsigned CNT_W      = 16,
    parameter logic [7:0]  CLR_ID     = PORT_CLR,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       press_flag,
    output logic [7:0] press_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             pinSync;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             pressPulse_q;
    logic             releasePulse_q;
    logic             pressFlag_q;
    logic             pressFlag_d;
    logic [7:0]       pressCnt_q;
    logic [7:0]       pressCnt_d;
    logic             pressEvent;
    logic             releaseEvent;
    logic             clr;

    sync_2ff #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(pin),
        .q_o(pinSync)
    );

    // Any return of the synchronised input to the current level restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (pinSync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = pinSync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign pressEvent   = level_q & ~level_d;
    assign releaseEvent = ~level_q & level_d;
    assign clr          = isPortWrite(write_strobe, port_id, CLR_ID);

    // A press on the same edge as a clear wins, leaving a count of one.
    always_comb begin
        pressFlag_d = pressFlag_q;
        pressCnt_d  = pressCnt_q;
        if (pressEvent) begin
            pressFlag_d = 1'b1;
            pressCnt_d  = clr ? 8'h01 : pressCnt_q + 8'h01;
        end else if (clr) begin
            pressFlag_d = 1'b0;
            pressCnt_d  = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            level_q        <= IDLE_LEVEL;
            pressPulse_q   <= 1'b0;
            releasePulse_q <= 1'b0;
            pressFlag_q    <= 1'b0;
            pressCnt_q     <= 8'h00;
        end else begin
            cnt_q          <= cnt_d;
            level_q        <= level_d;
            pressPulse_q   <= pressEvent;
            releasePulse_q <= releaseEvent;
            pressFlag_q    <= pressFlag_d;
            pressCnt_q     <= pressCnt_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = pressPulse_q;
    assign release_pulse = releasePulse_q;
    assign press_flag    = pressFlag_q;
    assign press_cnt     = pressCnt_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE=4: a window-based reference model
// queues the expected outputs each edge and a monitor compares them on the falling edge.
module tb_btn_conditioner;

    localparam int         D   = 4;
    localparam logic [7:0] CLR = 8'h00;

    typedef struct packed {
        logic       level;
        logic       pressPulse;
        logic       releasePulse;
        logic       pressFlag;
        logic [7:0] pressCnt;
    } expT;

    localparam expT RESET_EXP = '{level: 1'b1, pressPulse: 1'b0, releasePulse: 1'b0,
                                  pressFlag: 1'b0, pressCnt: 8'h00};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic [7:0] port_id = 8'hFF;
    logic       write_strobe = 1'b0;
    logic       level;
    logic       press_pulse;
    logic       release_pulse;
    logic       press_flag;
    logic [7:0] press_cnt;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;

    btn_conditioner #(
        .DEBOUNCE(D),
        .CNT_W(16),
        .CLR_ID(CLR),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pin(pin),
        .port_id(port_id),
        .write_strobe(write_strobe),
        .level(level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .press_flag(press_flag),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input expT exp);
        expT act;
        act = '{level: level, pressPulse: press_pulse, releasePulse: release_pulse,
                pressFlag: press_flag, pressCnt: press_cnt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t: got lvl=%b pp=%b rp=%b flag=%b cnt=%0d, expected lvl=%b pp=%b rp=%b flag=%b cnt=%0d",
                     name, $time, act.level, act.pressPulse, act.releasePulse, act.pressFlag,
                     act.pressCnt, exp.level, exp.pressPulse, exp.releasePulse, exp.pressFlag,
                     exp.pressCnt);
        end
    endtask

    task automatic applyStimulus(input logic pinVal, input int cycles);
        pin = pinVal;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulseWrite(input logic [7:0] id);
        write_strobe = 1'b1;
        port_id      = id;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = 8'hFF;
    endtask

    task automatic fullPress();
        applyStimulus(1'b0, D + 4);
        applyStimulus(1'b1, D + 4);
    endtask

    // Reference model: level flips once the last D synchronised samples all disagree with it.
    initial begin
        bit  pipe[$];
        bit  window[$];
        bit  mLevel;
        bit  s2Pre;
        bit  flipped;
        bit  mClr;
        int  mCnt;
        bit  mFlag;
        expT e;
        pipe   = '{1'b1, 1'b1};
        mLevel = 1'b1;
        mCnt   = 0;
        mFlag  = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pipe   = '{1'b1, 1'b1};
                window.delete();
                mLevel = 1'b1;
                mCnt   = 0;
                mFlag  = 1'b0;
                e      = RESET_EXP;
            end else begin
                s2Pre = pipe.pop_front();
                pipe.push_back(pin);
                window.push_back(s2Pre);
                if (window.size() > D) void'(window.pop_front());
                flipped = (window.size() == D);
                foreach (window[i]) if (window[i] == mLevel) flipped = 1'b0;
                mClr = write_strobe && (port_id == CLR);
                e.pressPulse   = flipped && mLevel;
                e.releasePulse = flipped && !mLevel;
                if (flipped) mLevel = !mLevel;
                if (e.pressPulse) begin
                    mFlag = 1'b1;
                    mCnt  = mClr ? 1 : (mCnt + 1) % 256;
                end else if (mClr) begin
                    mFlag = 1'b0;
                    mCnt  = 0;
                end
                e.level     = mLevel;
                e.pressFlag = mFlag;
                e.pressCnt  = 8'(mCnt);
            end
            expQ.push_back(e);
        end
    end

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("scoreboard", e);
            end
        end
    end

    initial begin
        int  run;
        int  sel;
        rst = 1'b1;
        pin = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 20);

        $display("[TB] single press and release");
        fullPress();

        $display("[TB] glitches shorter than debounce");
        repeat (10) begin
            applyStimulus(1'b0, D - 1);
            applyStimulus(1'b1, D - 1);
        end
        applyStimulus(1'b1, 10);

        $display("[TB] four presses then clear, then write to another port");
        repeat (4) fullPress();
        pulseWrite(CLR);
        applyStimulus(1'b1, 3);
        fullPress();
        pulseWrite(CLR + 8'h01);
        applyStimulus(1'b1, 3);

        $display("[TB] clear coincident with press");
        fullPress();
        pin = 1'b0;
        repeat (5) @(negedge clk);
        pulseWrite(CLR);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, D + 4);

        $display("[TB] 256 presses wrap the counter");
        pulseWrite(CLR);
        repeat (256) fullPress();

        $display("[TB] reset during debounce");
        applyStimulus(1'b1, 6);
        pin = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", RESET_EXP);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, D + 6);
        applyStimulus(1'b1, D + 4);

        $display("[TB] randomized pin and port writes");
        repeat (200) begin
            pin = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 2 * D + 2);
            repeat (run) begin
                if ($urandom_range(0, 11) == 0) begin
                    sel          = $urandom_range(0, 2);
                    write_strobe = 1'b1;
                    port_id      = (sel == 0) ? CLR : (sel == 1) ? CLR + 8'h01 : 8'($urandom_range(0, 255));
                end else begin
                    write_strobe = 1'b0;
                    port_id      = 8'hFF;
                end
                @(negedge clk);
            end
        end
        write_strobe = 1'b0;
        applyStimulus(1'b1, D + 4);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
